// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: two-requester round-robin front end for a single-port,
// synchronous-read memory macro, with a clear sweep that overwrites every
// location with CLR_VAL.
module sram_port_arbiter #(
   parameter int            AW      = 4,
   parameter int            DW      = 8,
   parameter logic [DW-1:0] CLR_VAL = '0
) (
   input  logic          clk,
   input  logic          rst,
   // requester A
   input  logic          req_a,
   input  logic          we_a,
   input  logic [AW-1:0] adr_a,
   input  logic [DW-1:0] wdat_a,
   output logic          gnt_a,
   output logic          rvalid_a,
   // requester B
   input  logic          req_b,
   input  logic          we_b,
   input  logic [AW-1:0] adr_b,
   input  logic [DW-1:0] wdat_b,
   output logic          gnt_b,
   output logic          rvalid_b,
   // shared read return
   output logic [DW-1:0] rdata,
   // clear sequencer
   input  logic          clr,
   output logic          busy,
   output logic          clr_done,
   // memory macro
   output logic [AW-1:0] mem_adr,
   output logic [DW-1:0] mem_dat_w,
   output logic          mem_we,
   input  logic [DW-1:0] mem_dat_r
);

   typedef enum logic {RUN, CLEAR} state_e;
   typedef enum logic {PRI_A, PRI_B} pri_e;

   localparam logic [AW-1:0] CNT_LAST = '1;

   state_e        state_q, state_d;
   pri_e          pri_q, pri_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          rv_a_q, rv_b_q;
   logic          done_q;

   // State register: FSM state, sweep counter, priority pointer, read tags
   // and the clear-done pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
         pri_q   <= PRI_A;
         rv_a_q  <= 1'b0;
         rv_b_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pri_q   <= pri_d;
         // A read tag is set only by a granted read; it is never flushed.
         rv_a_q  <= gnt_a & ~we_a;
         rv_b_q  <= gnt_b & ~we_b;
         done_q  <= (state_q == CLEAR) && (cnt_q == CNT_LAST);
      end
   end

   // Next-state logic: enter CLEAR on clr, step the sweep, rotate priority.
   always_comb begin
      // NOTE: defaults first so every path assigns every variable and no
      // latch is inferred.
      state_d = state_q;
      cnt_d   = cnt_q;
      pri_d   = pri_q;
      unique case (state_q)
         RUN: begin
            if (clr) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end else if (gnt_a) begin
               pri_d = PRI_B;
            end else if (gnt_b) begin
               pri_d = PRI_A;
            end
         end
         CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // Output logic: arbitration and memory-port mux; clr blocks all grants.
   always_comb begin
      gnt_a     = 1'b0;
      gnt_b     = 1'b0;
      busy      = 1'b0;
      mem_we    = 1'b0;
      mem_adr   = '0;
      mem_dat_w = '0;
      unique case (state_q)
         RUN: begin
            if (!clr) begin
               if (req_a && (!req_b || pri_q == PRI_A)) begin
                  gnt_a     = 1'b1;
                  mem_we    = we_a;
                  mem_adr   = adr_a;
                  mem_dat_w = wdat_a;
               end else if (req_b) begin
                  gnt_b     = 1'b1;
                  mem_we    = we_b;
                  mem_adr   = adr_b;
                  mem_dat_w = wdat_b;
               end
            end
         end
         CLEAR: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_adr   = cnt_q;
            mem_dat_w = CLR_VAL;
         end
         default: ;
      endcase
   end

   assign rvalid_a = rv_a_q;
   assign rvalid_b = rv_b_q;
   assign clr_done = done_q;
   assign rdata    = mem_dat_r;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 16x8
// synchronous-read memory attached to the memory port.
module tb_sram_port_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_a, we_a, req_b, we_b;
   logic [3:0] adr_a, adr_b;
   logic [7:0] wdat_a, wdat_b;
   logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
   logic [7:0] rdata;
   logic       clr, busy, clr_done;
   logic [3:0] mem_adr;
   logic [7:0] mem_dat_w;
   logic       mem_we;
   logic [7:0] mem_dat_r;

   logic [7:0] mem [16];

   int checks = 0;
   int errors = 0;

   sram_port_arbiter #(.AW(4), .DW(8), .CLR_VAL(8'h00)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .we_a(we_a), .adr_a(adr_a), .wdat_a(wdat_a),
      .gnt_a(gnt_a), .rvalid_a(rvalid_a),
      .req_b(req_b), .we_b(we_b), .adr_b(adr_b), .wdat_b(wdat_b),
      .gnt_b(gnt_b), .rvalid_b(rvalid_b),
      .rdata(rdata),
      .clr(clr), .busy(busy), .clr_done(clr_done),
      .mem_adr(mem_adr), .mem_dat_w(mem_dat_w), .mem_we(mem_we),
      .mem_dat_r(mem_dat_r)
   );

   always #5 clk = ~clk;

   // Memory macro model: write on edge, registered-address read.
   always @(posedge clk) begin
      if (mem_we) mem[mem_adr] <= mem_dat_w;
      mem_dat_r <= mem[mem_adr];
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // 16 sweep cycles with reqs held; clr pulsed mid-sweep must be ignored.
   task automatic sweep();
      for (int j = 0; j < 16; j++) begin
         clr = (j == 5);
         #1;
         chk1("sweep_busy", busy, 1'b1);
         chk1("sweep_gnt_a", gnt_a, 1'b0);
         chk1("sweep_gnt_b", gnt_b, 1'b0);
         chk1("sweep_we", mem_we, 1'b1);
         chk4("sweep_adr", mem_adr, 4'(j));
         chk8("sweep_dat", mem_dat_w, 8'h00);
         chk1("sweep_done", clr_done, 1'b0);
         tick();
      end
      clr = 1'b0;
   endtask

   function automatic logic [7:0] after_abort(input int a);
      return (a < 5) ? 8'h00 : 8'(8'hA0 + a);
   endfunction

   initial begin
      for (int k = 0; k < 16; k++) mem[k] = 8'(8'h10 + k);
      mem[3] = 8'hFE;
      rst = 1'b0; clr = 1'b0;
      req_a = 1'b0; we_a = 1'b0; adr_a = '0; wdat_a = '0;
      req_b = 1'b0; we_b = 1'b0; adr_b = '0; wdat_b = '0;

      // Reset state
      #3;
      chk1("rst_gnt_a", gnt_a, 1'b0);
      chk1("rst_gnt_b", gnt_b, 1'b0);
      chk1("rst_rvalid_a", rvalid_a, 1'b0);
      chk1("rst_rvalid_b", rvalid_b, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", clr_done, 1'b0);
      chk1("rst_we", mem_we, 1'b0);
      tick();
      rst = 1'b1;
      tick();

      // Single read by A of preloaded address 3
      req_a = 1'b1; adr_a = 4'd3;
      #1;
      chk1("rd3_gnt_a", gnt_a, 1'b1);
      chk1("rd3_gnt_b", gnt_b, 1'b0);
      chk4("rd3_adr", mem_adr, 4'd3);
      chk1("rd3_we", mem_we, 1'b0);
      tick();
      req_a = 1'b0;
      #1;
      chk1("rd3_rvalid_a", rvalid_a, 1'b1);
      chk1("rd3_rvalid_b", rvalid_b, 1'b0);
      chk8("rd3_rdata", rdata, 8'hFE);

      // Fresh reset, then both read continuously: A,B,A,B...
      rst = 1'b0; #1; rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         req_a = 1'b1; adr_a = 4'(i);
         req_b = 1'b1; adr_b = 4'(i + 8);
         #1;
         chk1("rr_gnt_a", gnt_a, (i % 2) == 0);
         chk1("rr_gnt_b", gnt_b, (i % 2) == 1);
         if (i > 0) begin
            chk1("rr_rvalid_a", rvalid_a, (i % 2) == 1);
            chk1("rr_rvalid_b", rvalid_b, (i % 2) == 0);
            chk8("rr_rdata", rdata, ((i % 2) == 1) ? 8'(8'h10 + i - 1) : 8'(8'h10 + i + 7));
         end
         tick();
      end
      req_a = 1'b0; req_b = 1'b0;
      #1;
      chk1("rr_last_rvalid_b", rvalid_b, 1'b1);
      chk1("rr_last_rvalid_a", rvalid_a, 1'b0);
      chk8("rr_last_rdata", rdata, 8'h1F);
      tick();

      // A writes 0x5A to 7, B reads 7 the next cycle
      req_a = 1'b1; we_a = 1'b1; adr_a = 4'd7; wdat_a = 8'h5A;
      #1;
      chk1("wr_gnt_a", gnt_a, 1'b1);
      chk1("wr_we", mem_we, 1'b1);
      chk4("wr_adr", mem_adr, 4'd7);
      chk8("wr_dat", mem_dat_w, 8'h5A);
      tick();
      req_a = 1'b0; we_a = 1'b0;
      req_b = 1'b1; adr_b = 4'd7;
      #1;
      chk1("raw_gnt_b", gnt_b, 1'b1);
      chk1("wr_no_rvalid_a", rvalid_a, 1'b0);
      tick();
      req_b = 1'b0;
      #1;
      chk1("raw_rvalid_b", rvalid_b, 1'b1);
      chk8("raw_rdata", rdata, 8'h5A);
      tick();

      // Read by A in N, clr in N+1 with both requesting
      req_a = 1'b1; adr_a = 4'd7;
      #1;
      chk1("pend_gnt_a", gnt_a, 1'b1);
      tick();
      req_b = 1'b1; adr_b = 4'd9; adr_a = 4'd15; clr = 1'b1;
      #1;
      chk1("pend_rvalid_a", rvalid_a, 1'b1);
      chk8("pend_rdata", rdata, 8'h5A);
      chk1("dead_gnt_a", gnt_a, 1'b0);
      chk1("dead_gnt_b", gnt_b, 1'b0);
      chk1("dead_we", mem_we, 1'b0);
      chk1("dead_busy", busy, 1'b0);
      tick();
      clr = 1'b0;
      #1;
      chk1("sweep0_rvalid_a", rvalid_a, 1'b0);
      sweep();

      // clr_done cycle accepts a back-to-back clr
      clr = 1'b1;
      #1;
      chk1("done1_pulse", clr_done, 1'b1);
      chk1("done1_busy", busy, 1'b0);
      chk1("b2b_gnt_a", gnt_a, 1'b0);
      chk1("b2b_gnt_b", gnt_b, 1'b0);
      tick();
      clr = 1'b0;
      sweep();

      // Grants resume with pri still pointing at B
      #1;
      chk1("done2_pulse", clr_done, 1'b1);
      chk1("resume_gnt_b", gnt_b, 1'b1);
      chk1("resume_gnt_a", gnt_a, 1'b0);
      tick();
      #1;
      chk1("done2_drop", clr_done, 1'b0);
      chk1("resume2_gnt_a", gnt_a, 1'b1);
      chk1("clr_rvalid_b", rvalid_b, 1'b1);
      chk8("clr_rdata_b", rdata, 8'h00);
      tick();
      req_a = 1'b0; req_b = 1'b0;
      #1;
      chk1("clr_rvalid_a", rvalid_a, 1'b1);
      chk8("clr_rdata_a", rdata, 8'h00);
      tick();

      // Fill memory with A0+k, then abort a sweep at cnt=5 with reset
      for (int k = 0; k < 16; k++) begin
         req_a = 1'b1; we_a = 1'b1; adr_a = 4'(k); wdat_a = 8'(8'hA0 + k);
         #1;
         chk1("fill_gnt_a", gnt_a, 1'b1);
         tick();
      end
      req_a = 1'b0; we_a = 1'b0; clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int j = 0; j < 5; j++) begin
         #1;
         chk4("abort_adr", mem_adr, 4'(j));
         tick();
      end
      #1;
      chk4("abort_adr5", mem_adr, 4'd5);
      chk1("abort_busy_pre", busy, 1'b1);
      rst = 1'b0;
      #1;
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_done", clr_done, 1'b0);
      chk1("abort_rvalid_a", rvalid_a, 1'b0);
      chk1("abort_rvalid_b", rvalid_b, 1'b0);
      chk1("abort_we", mem_we, 1'b0);
      tick();
      rst = 1'b1;

      // After release: pri=A, and memory shows the partial sweep
      for (int k = 0; k < 16; k++) begin
         req_a = 1'b1; adr_a = 4'(k);
         req_b = (k == 0); adr_b = 4'd0;
         #1;
         chk1("post_gnt_a", gnt_a, 1'b1);
         chk1("post_gnt_b", gnt_b, 1'b0);
         if (k > 0) begin
            chk1("post_rvalid_a", rvalid_a, 1'b1);
            chk8("post_rdata", rdata, after_abort(k - 1));
         end
         tick();
      end
      req_a = 1'b0; req_b = 1'b0;
      #1;
      chk1("post_last_rvalid_a", rvalid_a, 1'b1);
      chk8("post_last_rdata", rdata, after_abort(15));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Round-robin controller that shares one single-port, synchronous-read 16x8 memory between two requesters (A, B). It also provides a clear sequencer that overwrites every location with a fixed value on command. It sits directly in front of the memory macro and drives the memory's address, write-data and write-enable, and returns read data to the requester that issued the read.

## Interface
Parameters:
- AW, 4, address width; memory depth 2^AW
- DW, 8, data width
- CLR_VAL, 8'h00, value written to every location during a clear sweep

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset; one clock, reset is asynchronous and active-low
- req_a / req_b  in  1  access request, level, held until granted
- we_a / we_b  in  1  1 = write, 0 = read
- adr_a / adr_b  in  AW  access address
- wdat_a / wdat_b  in  DW  write data
- gnt_a / gnt_b  out  1  access accepted this cycle (combinational)
- rvalid_a / rvalid_b  out  1  read data valid on rdata this cycle
- rdata  out  DW  read data, shared by both requesters
- clr  in  1  start clear sweep, sampled in RUN only
- busy  out  1  clear sweep in progress
- clr_done  out  1  one-cycle pulse when sweep completes
- mem_adr  out  AW  memory address
- mem_dat_w  out  DW  memory write data
- mem_we  out  1  memory write enable
- mem_dat_r  in  DW  memory read data; registered address, valid the cycle after mem_adr

## Operation
- FSM states RUN and CLEAR. Reset state is RUN.
- RUN, clr=0:
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester named by priority pointer `pri`. Reset value of `pri` is A.
  - After any grant, `pri` moves to the requester not granted.
  - The granted requester's adr/wdat/we drive mem_adr/mem_dat_w/mem_we. At most one gnt is high per cycle.
  - With no grant: mem_we=0, mem_adr=0, mem_dat_w=0.
- Reads: a granted read sets a registered tag, so rvalid_x=1 on the next cycle. rdata = mem_dat_r passthrough. Writes never produce rvalid.
- RUN, clr=1 (clr has priority over requesters):
  - No gnt and no memory access that cycle.
  - Sweep counter cnt := 0; next state CLEAR.
  - `pri` is unchanged.
- CLEAR:
  - busy=1, gnt_a=gnt_b=0.
  - mem_we=1, mem_adr=cnt, mem_dat_w=CLR_VAL; cnt increments.
  - At cnt = 2^AW-1: that write occurs, next state is RUN, and clr_done pulses on the following cycle (the first RUN cycle).
  - clr is ignored while in CLEAR.
- Pending read: a read granted in the cycle clr is sampled (impossible, since clr blocks grants) or in the cycle before still returns rvalid on the next cycle. The return pipeline is never flushed except by reset.
- Reset (rst=0), asynchronous at any time including mid-sweep:
  - state=RUN, cnt=0, pri=A.
  - rvalid_a=rvalid_b=0, busy=0, clr_done=0.
  - A partial sweep is abandoned; locations not yet written keep their contents.
- Reset values of outputs: gnt_*=0 (no req), rvalid_*=0, busy=0, clr_done=0, mem_we=0. rdata follows mem_dat_r.

## Timing
- Grant latency 0: gnt_x rises in the same cycle as req_x when arbitration selects x.
- Read latency 1: grant in cycle N, rvalid_x and rdata valid in N+1.
- Write commits at the rising edge ending cycle N. A read of the same address granted in N+1 returns the new data.
- Sustained throughput is one access per cycle. With both requesting continuously: grants alternate strictly A,B,A,B.
- Clear cost is 1 + 2^AW cycles of no grants (17 at AW=4). busy is high for exactly 2^AW cycles. clr_done pulses on the cycle after busy falls.
- Back-to-back clr: a new clr is accepted in the first RUN cycle after the sweep, including the clr_done cycle.

## Test plan
- Memory preloaded with 0xFE at address 3; after reset, A read adr 3 -> gnt_a same cycle, rvalid_a=1 next cycle with rdata=0xFE, rvalid_b=0.
- Both requesters read continuously from reset -> gnt sequence A,B,A,B for 8 cycles; each rvalid_x lags its gnt_x by one cycle; never both gnt in one cycle.
- A writes 0x5A to adr 7, B reads adr 7 in the next cycle -> gnt_b, then rvalid_b with rdata=0x5A.
- clr pulse while req_a and req_b are held high:
  - 1 dead cycle, then 16 cycles of busy=1 with mem_we=1, mem_adr 0..15, mem_dat_w=0x00.
  - Then clr_done pulse; grants resume with the unchanged `pri`.
  - A subsequent read of any address returns 0x00.
- Read granted to A in cycle N with clr asserted in N+1 -> rvalid_a with correct data in N+1; sweep still starts at N+2.
- rst driven low while cnt=5 in CLEAR -> busy, rvalid_*, clr_done drop immediately; after release, state=RUN and pri=A; addresses 0..4 read 0x00; addresses 6..15 keep their prior values.
